// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that shares one PIPO holding register among N requesters,
// issuing a single-cycle LOAD strobe per grant followed by a fixed idle gap.
module pipo_load_arbiter #(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      data_i,
  output logic [N-1:0]         ack,
  output logic                 load_o,
  output logic [DW-1:0]        data_o,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy_o
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, LOAD, GAPS} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [IW-1:0] prio, prio_n, win;
  logic          found, grant;
  int            scan_idx;

  // Rotating scan starting at prio; the first asserted request wins.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(prio) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = IW'(scan_idx);
      end
    end
  end

  assign grant  = (state == IDLE) && found;
  assign prio_n = (win == IW'(N - 1)) ? '0 : win + IW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (found) state_n = LOAD;
      LOAD: begin
        if (GAP > 0) begin
          state_n = GAPS;
          cnt_n   = 4'(GAP);
        end else begin
          state_n = IDLE;
        end
      end
      GAPS: begin
        if (cnt <= 4'd1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy_o <= (state_n != IDLE);
    end
  end

  // data_o and grant_id only change on a grant so the register input stays stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio     <= '0;
      load_o   <= 1'b0;
      ack      <= '0;
      data_o   <= '0;
      grant_id <= '0;
    end else begin
      load_o <= 1'b0;
      ack    <= '0;
      if (grant) begin
        load_o   <= 1'b1;
        ack      <= ONE << win;
        data_o   <= data_i[int'(win)*DW +: DW];
        grant_id <= win;
        prio     <= prio_n;
      end
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter: a GAP=1 instance and a GAP=0 instance,
// expected grants queued when requests are driven and popped on each load pulse.
module tb_pipo_load_arbiter;

  logic        clk, rst;
  logic [3:0]  req, req0;
  logic [63:0] data_i;
  logic [3:0]  ack, ack0;
  logic        load_o, load0;
  logic [15:0] data_o, data0;
  logic [1:0]  gid, gid0;
  logic        busy_o, busy0;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int n;

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] data;
    logic [1:0]  gid;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;

  pipo_load_arbiter #(.N(4), .DW(16), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req(req), .data_i(data_i), .ack(ack),
    .load_o(load_o), .data_o(data_o), .grant_id(gid), .busy_o(busy_o)
  );

  pipo_load_arbiter #(.N(4), .DW(16), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .data_i(data_i), .ack(ack0),
    .load_o(load0), .data_o(data0), .grant_id(gid0), .busy_o(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] slot(input int k);
    return 16'(16'h1111 * (k + 1));
  endfunction

  function automatic exp_t mkExp(input int g, input logic [15:0] d, input int c);
    exp_t e;
    e.ack  = 4'(1 << g);
    e.data = d;
    e.gid  = 2'(g);
    e.cyc  = c;
    return e;
  endfunction

  task automatic doReset();
    rst = 1'b0;
    req = '0;
    req0 = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  // One granted request on the GAP=1 instance; returns in IDLE.
  task automatic applyStimulus(input logic [3:0] reqv, input int g);
    q1.push_back(mkExp(g, slot(g), cyc + 1));
    req = reqv;
    tick(1);
    req = '0;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (load_o === 1'b1) begin
        if (q1.size() == 0) checkOutput("g1_unexpected_load", 1, 0);
        else begin
          e1 = q1.pop_front();
          checkOutput("g1_cycle", cyc, e1.cyc);
          checkOutput("g1_ack", {28'b0, ack}, {28'b0, e1.ack});
          checkOutput("g1_data", {16'b0, data_o}, {16'b0, e1.data});
          checkOutput("g1_gid", {30'b0, gid}, {30'b0, e1.gid});
        end
      end else checkOutput("g1_ack_idle", {28'b0, ack}, 0);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (load0 === 1'b1) begin
        if (q0.size() == 0) checkOutput("g0_unexpected_load", 1, 0);
        else begin
          e0 = q0.pop_front();
          checkOutput("g0_cycle", cyc, e0.cyc);
          checkOutput("g0_ack", {28'b0, ack0}, {28'b0, e0.ack});
          checkOutput("g0_data", {16'b0, data0}, {16'b0, e0.data});
          checkOutput("g0_gid", {30'b0, gid0}, {30'b0, e0.gid});
        end
      end else checkOutput("g0_ack_idle", {28'b0, ack0}, 0);
    end
  end

  initial begin
    rst    = 1'b0;
    req    = '0;
    req0   = '0;
    data_i = {slot(3), slot(2), slot(1), slot(0)};
    #3;
    checkOutput("rst_load", {31'b0, load_o}, 0);
    checkOutput("rst_ack", {28'b0, ack}, 0);
    checkOutput("rst_data", {16'b0, data_o}, 0);
    checkOutput("rst_gid", {30'b0, gid}, 0);
    checkOutput("rst_busy", {31'b0, busy_o}, 0);
    checkOutput("rst_load0", {31'b0, load0}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    checkOutput("busy_after_release", {31'b0, busy_o}, 0);

    // Single request with handshake drop; busy spans LOAD and GAP.
    data_i[15:0] = 16'hA5A5;
    q1.push_back(mkExp(0, 16'hA5A5, cyc + 1));
    req = 4'b0001;
    tick(1);
    checkOutput("single_busy_load", {31'b0, busy_o}, 1);
    req = '0;
    tick(1);
    checkOutput("single_busy_gap", {31'b0, busy_o}, 1);
    checkOutput("single_load_low", {31'b0, load_o}, 0);
    checkOutput("single_data_hold", {16'b0, data_o}, 32'hA5A5);
    tick(1);
    checkOutput("single_busy_idle", {31'b0, busy_o}, 0);
    data_i[15:0] = slot(0);

    // Full contention: rotation 0,1,2,3,0,1 with loads 3 cycles apart.
    doReset();
    n = cyc;
    for (int i = 0; i < 6; i++) q1.push_back(mkExp(i % 4, slot(i % 4), n + 1 + 3 * i));
    req = 4'b1111;
    tick(16);
    req = '0;
    tick(3);
    checkOutput("contention_drain", q1.size(), 0);

    // Pointer wrap: 2, then 3 (prio wraps to 0), then 0.
    doReset();
    applyStimulus(4'b0100, 2);
    applyStimulus(4'b1001, 3);
    applyStimulus(4'b1001, 0);
    checkOutput("wrap_drain", q1.size(), 0);

    // Reset during LOAD drops everything asynchronously.
    req = 4'b0010;
    tick(1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstload_load", {31'b0, load_o}, 0);
    checkOutput("rstload_ack", {28'b0, ack}, 0);
    checkOutput("rstload_data", {16'b0, data_o}, 0);
    checkOutput("rstload_busy", {31'b0, busy_o}, 0);
    req = '0;
    #1;
    rst = 1'b1;
    tick(1);
    checkOutput("rstload_busy_after", {31'b0, busy_o}, 0);

    // GAP=0 instance: back-to-back loads every 2 cycles alternating 0,1.
    n = cyc;
    for (int i = 0; i < 4; i++) q0.push_back(mkExp(i % 2, slot(i % 2), n + 1 + 2 * i));
    req0 = 4'b0011;
    tick(7);
    req0 = '0;
    tick(3);
    checkOutput("gap0_drain", q0.size(), 0);

    // Reset mid-GAP, release with req[2] pending; then prio must be 3.
    n = cyc;
    q1.push_back(mkExp(2, slot(2), n + 1));
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(1);
    checkOutput("midgap_busy_pre", {31'b0, busy_o}, 1);
    rst = 1'b0;
    #1;
    checkOutput("midgap_busy_rst", {31'b0, busy_o}, 0);
    req = 4'b0100;
    q1.push_back(mkExp(2, slot(2), n + 3));
    #2;
    rst = 1'b1;
    tick(1);
    req = '0;
    tick(2);
    applyStimulus(4'b1111, 3);
    checkOutput("midgap_drain", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
